// File: rtl/pattern_event_counter.sv
// pattern_event_counter
// Counts pattern A / pattern B pulses from the serial Mealy detector over a
// fixed window of enabled clock cycles. At each window end it publishes both
// counts as a snapshot behind a valid/ack handshake and flags overwritten,
// unacknowledged snapshots.
//
// Optional feature macro: PATTERN_COUNTER_SAT_EN
//   defined     : live counters saturate at all-ones, sticky `sat` port exists
//   not defined : live counters wrap modulo 2^WIDTH, no `sat` port
module pattern_event_counter #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       pattern,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count_a,
    output logic [WIDTH-1:0] count_b,
    output logic             valid,
    input  logic             ack,
    output logic             overrun
`ifdef PATTERN_COUNTER_SAT_EN
    ,
    output logic             sat
`endif
);

    // Window position counter spans 0..WINDOW-1.
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    // Output handshake state: FULL means a snapshot is waiting for ack.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIDTH-1:0] live_a_q, live_a_d;
    logic [WIDTH-1:0] live_b_q, live_b_d;
    logic [WIDTH-1:0] snap_a_q, snap_a_d;
    logic [WIDTH-1:0] snap_b_q, snap_b_d;
    logic             overrun_q, overrun_d;

    // Values the live counters take if the current cycle is counted.
    logic [WIDTH-1:0] live_a_inc;
    logic [WIDTH-1:0] live_b_inc;

    logic count_en;
    logic win_end;

`ifdef PATTERN_COUNTER_SAT_EN
    logic sat_q, sat_d;
    logic hit_a, hit_b;
`endif

    // clear overrides enable; a window ends on the last counted cycle.
    assign count_en = enable & ~clear;
    assign win_end  = count_en & (win_q == WIN_LAST);

    // Incremented live counts, including this cycle's pattern pulses.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first so that no path leaves it unassigned and infers a latch.
        live_a_inc = live_a_q;
        live_b_inc = live_b_q;
`ifdef PATTERN_COUNTER_SAT_EN
        hit_a = 1'b0;
        hit_b = 1'b0;
        if (pattern[1] && (live_a_q != CNT_MAX)) begin
            live_a_inc = live_a_q + CNT_ONE;
            hit_a      = (live_a_q == (CNT_MAX - CNT_ONE));
        end
        if (pattern[0] && (live_b_q != CNT_MAX)) begin
            live_b_inc = live_b_q + CNT_ONE;
            hit_b      = (live_b_q == (CNT_MAX - CNT_ONE));
        end
`else
        if (pattern[1]) begin
            live_a_inc = live_a_q + CNT_ONE;
        end
        if (pattern[0]) begin
            live_b_inc = live_b_q + CNT_ONE;
        end
`endif
    end

    // Window, live-counter, snapshot and sticky-flag next state.
    always_comb begin
        win_d     = win_q;
        live_a_d  = live_a_q;
        live_b_d  = live_b_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        overrun_d = overrun_q;

        if (clear) begin
            // Restart the window; this cycle's pattern is discarded.
            win_d    = '0;
            live_a_d = '0;
            live_b_d = '0;
        end else if (enable) begin
            if (win_end) begin
                snap_a_d = live_a_inc;
                snap_b_d = live_b_inc;
                win_d    = '0;
                live_a_d = '0;
                live_b_d = '0;
                // Overwriting a pending snapshot nobody accepted this cycle.
                if ((state_q == ST_FULL) && !ack) begin
                    overrun_d = 1'b1;
                end
            end else begin
                win_d    = win_q + WIN_ONE;
                live_a_d = live_a_inc;
                live_b_d = live_b_inc;
            end
        end
    end

`ifdef PATTERN_COUNTER_SAT_EN
    // Sticky saturation flag: set on the cycle a counted event reaches all-ones.
    always_comb begin
        sat_d = sat_q | (count_en & (hit_a | hit_b));
    end
`endif

    // Handshake FSM next state; a window end always (re)fills the snapshot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (win_end) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (win_end) begin
                    state_d = ST_FULL;
                end else if (ack) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values; the reset is synchronous, so
        // it lives inside the clocked branch rather than the sensitivity list.
        if (reset) begin
            state_q   <= ST_EMPTY;
            win_q     <= '0;
            live_a_q  <= '0;
            live_b_q  <= '0;
            snap_a_q  <= '0;
            snap_b_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            live_a_q  <= live_a_d;
            live_b_q  <= live_b_d;
            snap_a_q  <= snap_a_d;
            snap_b_q  <= snap_b_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PATTERN_COUNTER_SAT_EN
    // Sticky saturation register, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`endif

    assign count_a = snap_a_q;
    assign count_b = snap_b_q;
    assign valid   = (state_q == ST_FULL);
    assign overrun = overrun_q;

endmodule
